// File: rtl/addr_delocator.sv
// addr_delocator: splits a flat position address into inner/outer coordinates.
// Data words are divided by locate_dim_size with a 1-bit/cycle restoring divider;
// inner = remainder, outer = quotient. Control tokens are copied to both outputs.
module addr_delocator #(
  parameter int DATA_W  = 16,
  parameter int DIV_CYC = DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              flush,
  input  logic              tile_en,
  input  logic [DATA_W-1:0] locate_dim_size,
  input  logic [DATA_W:0]   addr_in,
  input  logic              addr_in_valid,
  output logic              addr_in_ready,
  output logic [DATA_W:0]   coord_out_0,
  output logic              coord_out_0_valid,
  input  logic              coord_out_0_ready,
  output logic [DATA_W:0]   coord_out_1,
  output logic              coord_out_1_valid,
  input  logic              coord_out_1_ready
);

  localparam int CNT_W = (DIV_CYC > 1) ? $clog2(DIV_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t            state_r;
  // Dividend shifts out of the MSB while quotient bits shift into the LSB.
  logic [DATA_W-1:0] dq_r;
  // One bit wider than the divisor so the shifted partial remainder never overflows.
  logic [DATA_W:0]   rem_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [DATA_W:0]   coord0_r;
  logic [DATA_W:0]   coord1_r;
  logic              taken0_r;
  logic              taken1_r;

  logic              gate_s;
  logic              hs_in_s;
  logic              hs0_s;
  logic              hs1_s;
  logic              taken0_nx_s;
  logic              taken1_nx_s;
  logic [DATA_W:0]   rem_shift_s;
  logic              rem_ge_s;
  logic [DATA_W:0]   rem_sub_s;
  logic [DATA_W-1:0] dq_nx_s;

  // Handshakes are only honoured with the tile enabled, the clock enabled and no clear pending.
  assign gate_s            = clk_en & tile_en & ~rst & ~flush;
  assign addr_in_ready     = (state_r == IDLE) & gate_s;
  assign coord_out_0_valid = (state_r == OUT) & ~taken0_r & gate_s;
  assign coord_out_1_valid = (state_r == OUT) & ~taken1_r & gate_s;
  assign coord_out_0       = coord0_r;
  assign coord_out_1       = coord1_r;

  assign hs_in_s     = addr_in_valid & addr_in_ready;
  assign hs0_s       = coord_out_0_valid & coord_out_0_ready;
  assign hs1_s       = coord_out_1_valid & coord_out_1_ready;
  assign taken0_nx_s = taken0_r | hs0_s;
  assign taken1_nx_s = taken1_r | hs1_s;

  // Restoring step: a set bit shifted out of rem_r means the true value already exceeds the divisor.
  assign rem_shift_s = {rem_r[DATA_W-1:0], dq_r[DATA_W-1]};
  assign rem_ge_s    = rem_r[DATA_W] | (rem_shift_s >= {1'b0, locate_dim_size});
  assign rem_sub_s   = rem_ge_s ? (rem_shift_s - {1'b0, locate_dim_size}) : rem_shift_s;
  assign dq_nx_s     = {dq_r[DATA_W-2:0], rem_ge_s};

  // Control FSM plus divider datapath and registered output words.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_r  <= IDLE;
      dq_r     <= '0;
      rem_r    <= '0;
      cnt_r    <= CNT_ZERO;
      coord0_r <= '0;
      coord1_r <= '0;
      taken0_r <= 1'b0;
      taken1_r <= 1'b0;
    end else if (clk_en) begin
      case (state_r)
        IDLE: begin
          if (hs_in_s) begin
            if (addr_in[DATA_W]) begin
              coord0_r <= addr_in;
              coord1_r <= addr_in;
              state_r  <= OUT;
            end else if (locate_dim_size == '0) begin
              coord0_r <= {1'b0, addr_in[DATA_W-1:0]};
              coord1_r <= '0;
              state_r  <= OUT;
            end else begin
              dq_r    <= addr_in[DATA_W-1:0];
              rem_r   <= '0;
              cnt_r   <= CNT_LAST;
              state_r <= DIV;
            end
          end
        end
        DIV: begin
          dq_r  <= dq_nx_s;
          rem_r <= rem_sub_s;
          if (cnt_r == CNT_ZERO) begin
            coord1_r <= {1'b0, dq_nx_s};
            coord0_r <= {1'b0, rem_sub_s[DATA_W-1:0]};
            state_r  <= OUT;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        OUT: begin
          if (taken0_nx_s && taken1_nx_s) begin
            taken0_r <= 1'b0;
            taken1_r <= 1'b0;
            state_r  <= IDLE;
          end else begin
            taken0_r <= taken0_nx_s;
            taken1_r <= taken1_nx_s;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addr_delocator.sv
// Directed self-checking bench for addr_delocator.
module tb_addr_delocator;

  logic        clk = 1'b0;
  logic        rst, clk_en, flush, tile_en;
  logic [15:0] locate_dim_size;
  logic [16:0] addr_in;
  logic        addr_in_valid, addr_in_ready;
  logic [16:0] coord_out_0, coord_out_1;
  logic        coord_out_0_valid, coord_out_0_ready;
  logic        coord_out_1_valid, coord_out_1_ready;

  int n_checks = 0;
  int n_fail   = 0;

  addr_delocator dut (
    .clk               (clk),
    .rst               (rst),
    .clk_en            (clk_en),
    .flush             (flush),
    .tile_en           (tile_en),
    .locate_dim_size   (locate_dim_size),
    .addr_in           (addr_in),
    .addr_in_valid     (addr_in_valid),
    .addr_in_ready     (addr_in_ready),
    .coord_out_0       (coord_out_0),
    .coord_out_0_valid (coord_out_0_valid),
    .coord_out_0_ready (coord_out_0_ready),
    .coord_out_1       (coord_out_1),
    .coord_out_1_valid (coord_out_1_valid),
    .coord_out_1_ready (coord_out_1_ready)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a word and return just after the edge that accepted it.
  task automatic accept(input logic [16:0] w);
    int k;
    addr_in       = w;
    addr_in_valid = 1'b1;
    k = 0;
    while (!addr_in_ready && k < 50) begin
      step();
      k++;
    end
    check("accept_ready", {31'd0, addr_in_ready}, 32'd1);
    step();
    addr_in_valid = 1'b0;
  endtask

  // Latency counted as edges from accept to the output handshake edge.
  task automatic wait_valid(output int lat);
    int k;
    k = 0;
    while (!coord_out_0_valid && k < 60) begin
      step();
      k++;
    end
    lat = k + 1;
  endtask

  task automatic run_word(input string tag, input logic [15:0] dim, input logic [16:0] w,
                          input int exp_lat, input logic [16:0] e0, input logic [16:0] e1);
    int lat;
    locate_dim_size = dim;
    accept(w);
    wait_valid(lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_c0"}, {15'd0, coord_out_0}, {15'd0, e0});
    check({tag, "_c1"}, {15'd0, coord_out_1}, {15'd0, e1});
    check({tag, "_v1"}, {31'd0, coord_out_1_valid}, 32'd1);
    step();
    check({tag, "_v0_drop"}, {31'd0, coord_out_0_valid}, 32'd0);
    check({tag, "_rdy_back"}, {31'd0, addr_in_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    int k;
    rst = 1'b1; flush = 1'b0; clk_en = 1'b1; tile_en = 1'b1;
    locate_dim_size = 16'd10; addr_in = 17'd0; addr_in_valid = 1'b0;
    coord_out_0_ready = 1'b1; coord_out_1_ready = 1'b1;

    // Reset state.
    step(); step();
    check("rst_ready", {31'd0, addr_in_ready}, 32'd0);
    check("rst_v0", {31'd0, coord_out_0_valid}, 32'd0);
    check("rst_v1", {31'd0, coord_out_1_valid}, 32'd0);
    check("rst_c0", {15'd0, coord_out_0}, 32'd0);
    check("rst_c1", {15'd0, coord_out_1}, 32'd0);
    rst = 1'b0;
    #1;
    check("idle_ready", {31'd0, addr_in_ready}, 32'd1);

    // Division results: 23/10, 65535/7, 500/1.
    run_word("d10_23", 16'd10, 17'd23, 17, 17'd3, 17'd2);
    run_word("d7_ffff", 16'd7, 17'h0FFFF, 17, 17'd1, 17'd9362);
    run_word("d1_500", 16'd1, 17'd500, 17, 17'd0, 17'd500);
    run_word("d65535_fffe", 16'hFFFF, 17'h0FFFE, 17, 17'h0FFFE, 17'd0);

    // Tokens pass through with 1-cycle latency, then data follows in order.
    run_word("tok_done", 16'd10, 17'h10100, 1, 17'h10100, 17'h10100);
    run_word("tok_s0", 16'd10, 17'h10000, 1, 17'h10000, 17'h10000);
    run_word("d10_5", 16'd10, 17'd5, 17, 17'd5, 17'd0);

    // Divide by zero: address straight to inner, outer is zero.
    run_word("d0_9", 16'd0, 17'd9, 1, 17'd9, 17'd0);

    // Backpressure on the outer output only.
    coord_out_1_ready = 1'b0;
    locate_dim_size = 16'd10;
    accept(17'd47);
    wait_valid(lat);
    check("bp_lat", lat, 17);
    check("bp_c0", {15'd0, coord_out_0}, 32'd7);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_v0_taken", {31'd0, coord_out_0_valid}, 32'd0);
      check("bp_v1_hold", {31'd0, coord_out_1_valid}, 32'd1);
      check("bp_c1_hold", {15'd0, coord_out_1}, 32'd4);
      check("bp_ready_low", {31'd0, addr_in_ready}, 32'd0);
    end
    coord_out_1_ready = 1'b1;
    step();
    check("bp_v1_drop", {31'd0, coord_out_1_valid}, 32'd0);
    check("bp_ready_back", {31'd0, addr_in_ready}, 32'd1);

    // tile_en low blocks acceptance in IDLE.
    tile_en = 1'b0;
    addr_in = 17'd11;
    addr_in_valid = 1'b1;
    step(); step();
    check("tile_ready", {31'd0, addr_in_ready}, 32'd0);
    check("tile_no_out", {31'd0, coord_out_0_valid}, 32'd0);
    addr_in_valid = 1'b0;
    tile_en = 1'b1;

    // rst pulse mid-DIV aborts the word.
    locate_dim_size = 16'd10;
    accept(17'd23);
    repeat (7) step();
    rst = 1'b1;
    #1;
    check("rstdiv_ready", {31'd0, addr_in_ready}, 32'd0);
    check("rstdiv_v0", {31'd0, coord_out_0_valid}, 32'd0);
    step();
    rst = 1'b0;
    #1;
    check("rstdiv_ready_after", {31'd0, addr_in_ready}, 32'd1);
    check("rstdiv_v1_after", {31'd0, coord_out_1_valid}, 32'd0);
    run_word("after_rst", 16'd10, 17'd11, 17, 17'd1, 17'd1);

    // flush pulse in OUT aborts the pending outputs.
    coord_out_0_ready = 1'b0;
    coord_out_1_ready = 1'b0;
    accept(17'd5);
    wait_valid(lat);
    check("fl_pre_v0", {31'd0, coord_out_0_valid}, 32'd1);
    flush = 1'b1;
    #1;
    check("fl_v0", {31'd0, coord_out_0_valid}, 32'd0);
    check("fl_v1", {31'd0, coord_out_1_valid}, 32'd0);
    check("fl_ready", {31'd0, addr_in_ready}, 32'd0);
    step();
    flush = 1'b0;
    #1;
    check("fl_c0_cleared", {15'd0, coord_out_0}, 32'd0);
    check("fl_v0_after", {31'd0, coord_out_0_valid}, 32'd0);
    check("fl_ready_after", {31'd0, addr_in_ready}, 32'd1);
    coord_out_0_ready = 1'b1;
    coord_out_1_ready = 1'b1;
    run_word("after_flush", 16'd10, 17'd11, 17, 17'd1, 17'd1);

    // clk_en low for 3 cycles mid-DIV stretches latency by 3.
    locate_dim_size = 16'd10;
    accept(17'd23);
    k = 0;
    repeat (5) begin step(); k++; end
    clk_en = 1'b0;
    #1;
    check("ce_ready", {31'd0, addr_in_ready}, 32'd0);
    repeat (3) begin step(); k++; end
    clk_en = 1'b1;
    while (!coord_out_0_valid && k < 60) begin
      step();
      k++;
    end
    check("ce_lat", k + 1, 20);
    check("ce_c0", {15'd0, coord_out_0}, 32'd3);
    check("ce_c1", {15'd0, coord_out_1}, 32'd2);
    step();
    check("ce_ready_back", {31'd0, addr_in_ready}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
